// File: rtl/mux2_1.sv
// Two-input selector with a registered copy of the output and a saturating
// count of select transitions on a clocked side-channel.
module mux2_1 #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data1_in,
    input  logic [WIDTH-1:0] data2_in,
    input  logic             sel,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data_out_q,
    output logic [CNT_W-1:0] sel_changes
);

    logic [WIDTH-1:0] r_data_q;
    logic [CNT_W-1:0] r_sel_changes;
    logic             r_sel_prev;
    logic             w_sel_toggled;

    // Conditional operator merges bitwise on an unknown select: bits where
    // both inputs agree pass through, the rest go X.
    assign data_out = sel ? data1_in : data2_in;

    assign w_sel_toggled = (sel != r_sel_prev);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_q      <= '0;
            r_sel_changes <= '0;
            r_sel_prev    <= 1'b0;
        end else begin
            r_data_q   <= data_out;
            r_sel_prev <= sel;
            if (w_sel_toggled && (r_sel_changes != '1)) begin
                r_sel_changes <= r_sel_changes + 1'b1;
            end
        end
    end

    assign data_out_q  = r_data_q;
    assign sel_changes = r_sel_changes;

endmodule

// File: tb/tb_mux2_1.sv
// Self-checking bench for mux2_1: truth table, 4:1 tree, registered output,
// reset behaviour, counter saturation and randomized checks against a model.
module tb_mux2_1;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    // Main clocked instance, WIDTH=8, CNT_W=8
    logic       rst;
    logic [7:0] d1, d2;
    logic       sel;
    logic [7:0] dout, dout_q;
    logic [7:0] chg;

    mux2_1 #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .reset(rst), .data1_in(d1), .data2_in(d2), .sel(sel),
        .data_out(dout), .data_out_q(dout_q), .sel_changes(chg)
    );

    // Saturation instance, CNT_W=3
    logic       s_rst;
    logic       s_sel;
    logic [7:0] s_d1, s_d2, s_out, s_q;
    logic [2:0] s_chg;

    mux2_1 #(.WIDTH(8), .CNT_W(3)) u_sat (
        .clk(clk), .reset(s_rst), .data1_in(s_d1), .data2_in(s_d2), .sel(s_sel),
        .data_out(s_out), .data_out_q(s_q), .sel_changes(s_chg)
    );

    // Purely combinational WIDTH=1 instance, clock and reset tied low
    logic       c_d1, c_d2, c_sel, c_out, c_q;
    logic [7:0] c_chg;

    mux2_1 #(.WIDTH(1), .CNT_W(8)) u_comb (
        .clk(1'b0), .reset(1'b0), .data1_in(c_d1), .data2_in(c_d2), .sel(c_sel),
        .data_out(c_out), .data_out_q(c_q), .sel_changes(c_chg)
    );

    // 4:1 tree built from three instances, no clock
    logic [3:0] t_in;
    logic [1:0] t_sel;
    logic       t_hi, t_lo, t_out;
    logic       t_q0, t_q1, t_q2;
    logic [7:0] t_c0, t_c1, t_c2;

    mux2_1 #(.WIDTH(1), .CNT_W(8)) u_t_hi (
        .clk(1'b0), .reset(1'b0), .data1_in(t_in[3]), .data2_in(t_in[2]), .sel(t_sel[0]),
        .data_out(t_hi), .data_out_q(t_q0), .sel_changes(t_c0)
    );
    mux2_1 #(.WIDTH(1), .CNT_W(8)) u_t_lo (
        .clk(1'b0), .reset(1'b0), .data1_in(t_in[1]), .data2_in(t_in[0]), .sel(t_sel[0]),
        .data_out(t_lo), .data_out_q(t_q1), .sel_changes(t_c1)
    );
    mux2_1 #(.WIDTH(1), .CNT_W(8)) u_t_root (
        .clk(1'b0), .reset(1'b0), .data1_in(t_hi), .data2_in(t_lo), .sel(t_sel[1]),
        .data_out(t_out), .data_out_q(t_q2), .sel_changes(t_c2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic d1;
        logic d2;
        logic s;
        logic exp;
    } comb_vec_t;

    typedef struct {
        logic [3:0] in;
        logic [1:0] s;
        logic       exp;
    } tree_vec_t;

    comb_vec_t cv[8];
    tree_vec_t tv[7];

    // Reference model state
    int unsigned m_cnt;
    int unsigned m_prev;
    int unsigned m_q;
    int unsigned m_out;

    initial begin
        rst = 1'b1; d1 = '0; d2 = '0; sel = 1'b0;
        s_rst = 1'b1; s_sel = 1'b0; s_d1 = 8'hFF; s_d2 = 8'h00;
        c_d1 = 1'b0; c_d2 = 1'b0; c_sel = 1'b0;
        t_in = '0; t_sel = '0;

        // Truth table: {d1, d2, sel} -> out
        cv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        cv[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        cv[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        cv[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
        cv[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        cv[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
        cv[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
        cv[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

        tv[0] = '{4'b0000, 2'b00, 1'b0};
        tv[1] = '{4'b0001, 2'b11, 1'b0};
        tv[2] = '{4'b0010, 2'b10, 1'b0};
        tv[3] = '{4'b0100, 2'b01, 1'b0};
        tv[4] = '{4'b1000, 2'b00, 1'b0};
        tv[5] = '{4'b1000, 2'b11, 1'b1};
        tv[6] = '{4'b0100, 2'b10, 1'b1};

        for (int i = 0; i < 8; i++) begin
            c_d1 = cv[i].d1; c_d2 = cv[i].d2; c_sel = cv[i].s;
            #10;
            check($sformatf("comb[%0d]", i), {31'd0, c_out}, {31'd0, cv[i].exp});
        end

        for (int i = 0; i < 7; i++) begin
            t_in = tv[i].in; t_sel = tv[i].s;
            #10;
            check($sformatf("tree[%0d]", i), {31'd0, t_out}, {31'd0, tv[i].exp});
        end

        // Random tree check: result is the indexed input
        for (int i = 0; i < 20; i++) begin
            logic [3:0] rin;
            int unsigned idx;
            rin = 4'($urandom);
            idx = $urandom_range(3, 0);
            t_in = rin; t_sel = 2'(idx);
            #10;
            check("tree_rand", {31'd0, t_out}, {31'd0, rin[idx]});
        end

        // Reset state
        tick();
        check("rst_q", {24'd0, dout_q}, 32'd0);
        check("rst_cnt", {24'd0, chg}, 32'd0);

        // Registered output, sel=1 then sel=0
        rst = 1'b0; d1 = 8'hA5; d2 = 8'h3C; sel = 1'b1;
        #10;
        check("out_sel1", {24'd0, dout}, 32'hA5);
        tick();
        check("q_sel1", {24'd0, dout_q}, 32'hA5);
        check("cnt_after1", {24'd0, chg}, 32'd1);
        sel = 1'b0;
        #10;
        check("out_sel0", {24'd0, dout}, 32'h3C);
        tick();
        check("q_sel0", {24'd0, dout_q}, 32'h3C);
        sel = 1'b1;
        tick();
        check("pre_rst_q", {24'd0, dout_q}, 32'hA5);
        check("pre_rst_cnt", {24'd0, chg}, 32'd3);

        // Mid-run reset clears registers, combinational path unaffected
        rst = 1'b1;
        tick();
        check("midrst_q", {24'd0, dout_q}, 32'd0);
        check("midrst_cnt", {24'd0, chg}, 32'd0);
        check("midrst_out", {24'd0, dout}, 32'hA5);

        // Reset coinciding with a sel 0->1 change is not counted
        sel = 1'b0;
        tick();
        sel = 1'b1;
        tick();
        check("rst_sel_cnt", {24'd0, chg}, 32'd0);
        // sel_prev was cleared to 0 by reset, so sel=1 now counts once
        rst = 1'b0;
        tick();
        check("post_rst_cnt", {24'd0, chg}, 32'd1);
        check("post_rst_q", {24'd0, dout_q}, 32'hA5);

        // Saturation with CNT_W=3
        tick();
        s_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            s_sel = ~s_sel;
            tick();
            check($sformatf("sat[%0d]", k), {29'd0, s_chg}, (k + 1 > 7) ? 32'd7 : 32'(k + 1));
        end

        // Randomized run against the model
        m_cnt = 1; m_prev = 1; m_q = 32'hA5;
        for (int i = 0; i < 300; i++) begin
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            sel = 1'($urandom);
            rst = ($urandom_range(15, 0) == 0);
            m_out = (sel == 1'b1) ? int'(d1) : int'(d2);
            #10;
            check("rand_out", {24'd0, dout}, m_out);
            tick();
            if (rst) begin
                m_q = 0; m_cnt = 0; m_prev = 0;
            end else begin
                m_q = m_out;
                if (int'(sel) != m_prev && m_cnt < 255) m_cnt++;
                m_prev = int'(sel);
            end
            check("rand_q", {24'd0, dout_q}, m_q);
            check("rand_cnt", {24'd0, chg}, m_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
